// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter
// Shares one req/gnt/rvalid memory port between the fetch stage (read-only
// instruction requester) and the memory stage (read/write data requester).
// Address phases are arbitrated combinationally. The owner of every granted
// transaction is kept in an in-order FIFO so that each response is steered
// back to the requester that issued it. A bounded data-priority streak
// prevents fetch from being starved.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   instr_*                  fetch request side (req/addr in; gnt/rvalid/rdata/err out)
//   data_*                   data request side (req/we/be/addr/wdata in; gnt/rvalid/rdata/err out)
//   mem_*                    unified memory port (req/we/be/addr/wdata out; gnt/rvalid/rdata/err in)
module imem_dmem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned STK_W = $clog2(DATA_STREAK_MAX + 1);

  // Owner IDs stored in the tracking FIFO
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q [MAX_OUTSTANDING];
  logic               owner_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [STK_W-1:0]   streak_q, streak_d;
  logic               spurious_rsp_q, spurious_rsp_d;

  logic sel_i, sel_d;
  logic gnt_i, gnt_d;
  logic push, pop, room;
  logic head_owner;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Arbitration, address-phase steering and response routing
  always_comb begin
    state_d        = state_q;
    sel_i          = 1'b0;
    sel_d          = 1'b0;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'h0;
    mem_addr_o     = 32'h0;
    mem_wdata_o    = 32'h0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = 32'h0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = 32'h0;
    data_err_o     = 1'b0;

    pop        = mem_rvalid_i && (count_q != '0);
    head_owner = owner_q[rd_ptr_q];
    // A pop in this cycle frees a slot, so a full FIFO can still accept a grant
    room       = (count_q != CNT_W'(MAX_OUTSTANDING)) || pop;

    case (state_q)
      IDLE: begin
        if (room) begin
          if (instr_req_i && data_req_i) begin
            if (streak_q == STK_W'(DATA_STREAK_MAX)) sel_i = 1'b1;
            else                                     sel_d = 1'b1;
          end else begin
            sel_i = instr_req_i;
            sel_d = data_req_i;
          end
        end
        mem_req_o = sel_i | sel_d;
        if (sel_i && !mem_gnt_i) state_d = HOLD_I;
        if (sel_d && !mem_gnt_i) state_d = HOLD_D;
      end
      HOLD_I: begin
        sel_i     = 1'b1;
        mem_req_o = instr_req_i;
        // Dropping req before gnt abandons the transaction without a push
        if (!instr_req_i || mem_gnt_i) state_d = IDLE;
      end
      HOLD_D: begin
        sel_d     = 1'b1;
        mem_req_o = data_req_i;
        if (!data_req_i || mem_gnt_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gnt_i = sel_i && instr_req_i && mem_gnt_i;
    gnt_d = sel_d && data_req_i && mem_gnt_i;
    push  = gnt_i | gnt_d;

    if (sel_i) begin
      mem_addr_o = instr_addr_i;
      mem_be_o   = 4'hF;
    end else if (sel_d) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end

    if (pop) begin
      if (head_owner == OWN_I) begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mem_rdata_i;
        instr_err_o    = mem_err_i;
      end else begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = mem_rdata_i;
        data_err_o    = mem_err_i;
      end
    end

    instr_gnt_o = gnt_i;
    data_gnt_o  = gnt_d;

    // Outputs stay quiet while reset is held, whatever the inputs do
    if (rst) begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_be_o       = 4'h0;
      mem_addr_o     = 32'h0;
      mem_wdata_o    = 32'h0;
      instr_gnt_o    = 1'b0;
      data_gnt_o     = 1'b0;
      instr_rvalid_o = 1'b0;
      instr_rdata_o  = 32'h0;
      instr_err_o    = 1'b0;
      data_rvalid_o  = 1'b0;
      data_rdata_o   = 32'h0;
      data_err_o     = 1'b0;
    end
  end

  // Owner FIFO, streak counter and spurious-response flag next state
  always_comb begin
    owner_d = owner_q;
    if (push) owner_d[wr_ptr_q] = gnt_d ? OWN_D : OWN_I;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    streak_d = streak_q;
    if (gnt_i || !instr_req_i) begin
      streak_d = '0;
    end else if (gnt_d && (streak_q != STK_W'(DATA_STREAK_MAX))) begin
      streak_d = streak_q + STK_W'(1);
    end

    spurious_rsp_d = spurious_rsp_q | (mem_rvalid_i && (count_q == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= '{default: 1'b0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      streak_q       <= '0;
      spurious_rsp_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      streak_q       <= streak_d;
      spurious_rsp_q <= spurious_rsp_d;
    end
  end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Self-checking bench for imem_dmem_port_arbiter: directed scenarios followed
// by randomized traffic, checked against a transaction-level reference model.
module tb_imem_dmem_port_arbiter;

  localparam int MAXO = 2;
  localparam int SMAX = 4;

  logic        clk;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rdata_i;

  imem_dmem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .DATA_STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding owners in issue order (0=instr, 1=data)
  int  sb_q[$];
  byte gnt_log[$];
  int  hold_own = -1;
  int  streak   = 0;
  bit  i_done, d_done;

  int          drv, own_m;
  logic        req_on, eg_i, eg_d;
  logic [31:0] e_addr, e_wdata;
  logic [4:0]  e_webe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops the expected owner whenever memory returns data
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      chk("rst_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    end else if (mem_rvalid_i && sb_q.size() > 0) begin
      own_m = sb_q.pop_front();
      chk("i_rvalid", {31'd0, instr_rvalid_o}, (own_m == 0) ? 32'd1 : 32'd0);
      chk("i_rdata",  instr_rdata_o, (own_m == 0) ? mem_rdata_i : 32'd0);
      chk("i_err",    {31'd0, instr_err_o}, (own_m == 0) ? {31'd0, mem_err_i} : 32'd0);
      chk("d_rvalid", {31'd0, data_rvalid_o}, (own_m == 1) ? 32'd1 : 32'd0);
      chk("d_rdata",  data_rdata_o, (own_m == 1) ? mem_rdata_i : 32'd0);
      chk("d_err",    {31'd0, data_err_o}, (own_m == 1) ? {31'd0, mem_err_i} : 32'd0);
    end else begin
      chk("no_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
      chk("no_rdata", instr_rdata_o | data_rdata_o, 32'd0);
    end
  end

  // Address-phase checker: decides who should own the port this cycle
  always begin
    @(negedge clk);
    #2;
    i_done = 1'b0;
    d_done = 1'b0;
    if (rst) begin
      sb_q.delete();
      hold_own = -1;
      streak   = 0;
      chk("rst_ctrl", {24'd0, mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o}, 32'd0);
      chk("rst_addr", mem_addr_o | mem_wdata_o, 32'd0);
    end else begin
      if (hold_own >= 0)                  drv = hold_own;
      else if (sb_q.size() >= MAXO)       drv = -1;
      else if (instr_req_i && data_req_i) drv = (streak == SMAX) ? 0 : 1;
      else if (data_req_i)                drv = 1;
      else if (instr_req_i)               drv = 0;
      else                                drv = -1;
      req_on = (drv == 0) ? instr_req_i : (drv == 1) ? data_req_i : 1'b0;
      e_addr = (drv == 0) ? instr_addr_i : (drv == 1) ? data_addr_i : 32'd0;
      e_wdata = (drv == 1) ? data_wdata_i : 32'd0;
      e_webe = (drv == 0) ? 5'h0F : (drv == 1) ? {data_we_i, data_be_i} : 5'h00;
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, req_on});
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_wdata", mem_wdata_o, e_wdata);
      chk("mem_we_be", {27'd0, mem_we_o, mem_be_o}, {27'd0, e_webe});
      eg_i = (drv == 0) && req_on && mem_gnt_i;
      eg_d = (drv == 1) && req_on && mem_gnt_i;
      chk("instr_gnt", {31'd0, instr_gnt_o}, {31'd0, eg_i});
      chk("data_gnt", {31'd0, data_gnt_o}, {31'd0, eg_d});
      if (eg_i) begin sb_q.push_back(0); gnt_log.push_back("I"); i_done = 1'b1; end
      if (eg_d) begin sb_q.push_back(1); gnt_log.push_back("D"); d_done = 1'b1; end
      if (eg_i || !instr_req_i)   streak = 0;
      else if (eg_d && streak < SMAX) streak++;
      hold_own = (drv >= 0 && req_on && !mem_gnt_i) ? drv : -1;
    end
  end

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
  endtask

  // Advance to the next drive point; response inputs are single-cycle pulses
  task automatic cyc();
    @(negedge clk);
    mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && sb_q.size() > 0; k++) begin
      cyc(); idle_inputs();
      mem_rvalid_i = 1; mem_rdata_i = $urandom;
    end
    cyc(); idle_inputs();
    chk("drained", sb_q.size(), 32'd0);
  endtask

  string exp_seq;

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; idle_inputs();

    // Fetch-only read, response two cycles after the grant
    cyc(); instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    #3 chk("t1_be", {28'd0, mem_be_o}, 32'hF);
    cyc(); instr_req_i = 0; mem_gnt_i = 0;
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    #3 chk("t1_rdata", instr_rdata_o, 32'hDEADBEEF);
    cyc();

    // Both requesting with immediate responses: bounded data streak
    gnt_log.delete();
    for (int k = 0; k < 10; k++) begin
      cyc();
      instr_req_i = 1; instr_addr_i = 32'h400 + 32'(4 * k);
      data_req_i = 1; data_addr_i = 32'h800 + 32'(4 * k); data_be_i = 4'hF;
      mem_gnt_i = 1; mem_rvalid_i = (k > 0); mem_rdata_i = 32'(k);
    end
    cyc(); idle_inputs(); mem_rvalid_i = 1; mem_rdata_i = 32'h99;
    cyc();
    exp_seq = "DDDDIDDDDI";
    chk("t2_len", gnt_log.size(), 32'd10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++) chk("t2_seq", 32'(gnt_log[i]), 32'(exp_seq[i]));

    // Data write stalled three cycles while fetch starts requesting
    drain();
    gnt_log.delete();
    cyc(); data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h200; data_wdata_i = 32'h1234;
    cyc(); instr_req_i = 1; instr_addr_i = 32'h300;
    cyc();
    #3 chk("t3_addr", mem_addr_o, 32'h200);
    cyc(); mem_gnt_i = 1;
    #3 chk("t3_dgnt", {31'd0, data_gnt_o}, 32'd1);
    cyc(); data_req_i = 0;
    cyc(); instr_req_i = 0; mem_gnt_i = 0;
    chk("t3_order", {16'd0, gnt_log.size() > 0 ? gnt_log[0] : 8'd0, gnt_log.size() > 1 ? gnt_log[1] : 8'd0}, {16'd0, 8'h44, 8'h49});
    drain();

    // Owner FIFO full, then simultaneous pop and push
    cyc(); instr_req_i = 1; instr_addr_i = 32'h10; mem_gnt_i = 1;
    cyc(); instr_addr_i = 32'h14;
    cyc(); instr_addr_i = 32'h18;
    #3 chk("t4_full", {31'd0, mem_req_o}, 32'd0);
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hA;
    #3 chk("t4_pushpop", {30'd0, instr_gnt_o, instr_rvalid_o}, 32'd3);
    cyc(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hB;
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'hC;
    cyc();
    chk("t4_empty", sb_q.size(), 32'd0);

    // Interleaved D then I, error on the first response
    cyc(); data_req_i = 1; data_we_i = 0; data_addr_i = 32'h40; mem_gnt_i = 1;
    cyc(); data_req_i = 0; instr_req_i = 1; instr_addr_i = 32'h44;
    cyc(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'h55;
    #3 chk("t5_derr", {30'd0, data_rvalid_o, data_err_o}, 32'd3);
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'h66;
    #3 chk("t5_irsp", {30'd0, instr_rvalid_o, instr_err_o}, 32'd2);
    cyc();

    // Owner drops req while held: no grant for the other side that cycle
    cyc(); instr_req_i = 1; instr_addr_i = 32'h60; mem_gnt_i = 0;
    cyc(); instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h64; mem_gnt_i = 1;
    #3 chk("drop_nognt", {30'd0, data_gnt_o, mem_req_o}, 32'd0);
    cyc();
    cyc(); data_req_i = 0; mem_gnt_i = 0;
    drain();

    // Reset while holding a data request with one fetch outstanding
    cyc(); instr_req_i = 1; instr_addr_i = 32'h70; mem_gnt_i = 1;
    cyc(); instr_req_i = 0; data_req_i = 1; data_we_i = 1; data_addr_i = 32'h80; mem_gnt_i = 0;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; idle_inputs();
    #3 chk("t6_flag_clr", {31'd0, dut.spurious_rsp_q}, 32'd0);
    cyc(); mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    #3 chk("t6_drop", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    cyc();
    #3 chk("t6_flag", {31'd0, dut.spurious_rsp_q}, 32'd1);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (!instr_req_i || i_done) begin
        instr_req_i = 1'($urandom_range(0, 1));
        instr_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req_i || d_done) begin
        data_req_i = 1'($urandom_range(0, 1));
        data_we_i = 1'($urandom_range(0, 1));
        data_be_i = 4'($urandom);
        data_addr_i = $urandom;
        data_wdata_i = $urandom;
      end
      mem_gnt_i = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = (sb_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i = $urandom;
      mem_err_i = ($urandom_range(0, 7) == 0);
    end
    cyc(); idle_inputs();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
